// File: rtl/alarm_icon_overlay.sv
// Alarm icon overlay: draws a scaled glyph strip from the font ROM and
// blinks/dims it according to a ringing/silenced alarm state machine.
module alarm_icon_overlay #(
  parameter int unsigned X0             = 576,
  parameter int unsigned Y0             = 320,
  parameter int unsigned N_GLYPH        = 2,
  parameter int unsigned SCALE_LOG2     = 2,
  parameter logic [6:0]  GLYPH_BASE     = 7'd6,
  parameter logic [11:0] FG_COLOR       = 12'hF00,
  parameter logic [11:0] BG_COLOR       = 12'h000,
  parameter logic [11:0] DIM_COLOR      = 12'h444,
  parameter int unsigned BLINK_FRAMES   = 15,
  parameter int unsigned TIMEOUT_FRAMES = 1800
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        alarm_req,
  input  logic        enable,
  input  logic        ack,
  input  logic        frame_tick,
  input  logic        video_on,
  input  logic [9:0]  pix_x,
  input  logic [9:0]  pix_y,
  output logic [10:0] rom_addr,
  input  logic [7:0]  rom_data,
  output logic [11:0] rgb_out,
  output logic        ringing
);

  localparam int unsigned CW         = 12;
  localparam int unsigned S          = 1 << SCALE_LOG2;
  localparam int unsigned ICON_W     = 8 * N_GLYPH * S;
  localparam int unsigned ICON_H     = 16 * S;
  localparam int unsigned BW         = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int unsigned RW         = (TIMEOUT_FRAMES > 0) ? $clog2(TIMEOUT_FRAMES + 1) : 1;
  localparam int unsigned BLINK_LAST = BLINK_FRAMES - 1;
  localparam int unsigned RING_LAST  = (TIMEOUT_FRAMES > 0) ? TIMEOUT_FRAMES - 1 : 0;

  typedef enum logic [1:0] {IDLE, RINGING, SILENCED} state_t;

  state_t          state_q, state_d;
  logic [BW-1:0]   blink_cnt_q, blink_cnt_d;
  logic [RW-1:0]   ring_cnt_q, ring_cnt_d;
  logic            phase_q, phase_d;

  logic [CW-1:0]   px_c, py_c, dx_c, dy_c;
  logic            in_c;
  logic [1:0]      glyph_c;
  logic [2:0]      col_c;
  logic [3:0]      row_c;
  logic [6:0]      code_c;
  logic [2:0]      col_s1, col_s2;
  logic            in_s1, in_s2, vid_s1, vid_s2;
  logic            pix_bit_c, timeout_c;
  logic [11:0]     rgb_c;

  // Region test and glyph/column/row decode of the incoming pixel
  always_comb begin
    px_c    = CW'(pix_x);
    py_c    = CW'(pix_y);
    dx_c    = px_c - CW'(X0);
    dy_c    = py_c - CW'(Y0);
    in_c    = (px_c >= CW'(X0)) && (px_c < CW'(X0 + ICON_W)) &&
              (py_c >= CW'(Y0)) && (py_c < CW'(Y0 + ICON_H));
    glyph_c = 2'(dx_c >> (3 + SCALE_LOG2));
    col_c   = 3'(dx_c >> SCALE_LOG2);
    row_c   = 4'(dy_c >> SCALE_LOG2);
    code_c  = GLYPH_BASE + 7'(glyph_c);
  end

  // Colour selection once the ROM row lines up with the delayed pixel
  always_comb begin
    pix_bit_c = rom_data[3'd7 - col_s2];
    rgb_c     = '0;
    if (vid_s2 && in_s2) begin
      case (state_q)
        RINGING:  if (phase_q) rgb_c = pix_bit_c ? FG_COLOR : BG_COLOR;
        SILENCED: rgb_c = pix_bit_c ? DIM_COLOR : BG_COLOR;
        default:  rgb_c = '0;
      endcase
    end
  end

  // Three-stage pixel pipeline: ROM address, ROM wait, colour
  always_ff @(posedge clk) begin
    if (reset) begin
      rom_addr <= '0;
      col_s1   <= '0;
      col_s2   <= '0;
      in_s1    <= 1'b0;
      in_s2    <= 1'b0;
      vid_s1   <= 1'b0;
      vid_s2   <= 1'b0;
      rgb_out  <= '0;
    end else begin
      rom_addr <= in_c ? {code_c, row_c} : '0;
      col_s1   <= col_c;
      in_s1    <= in_c;
      vid_s1   <= video_on;
      col_s2   <= col_s1;
      in_s2    <= in_s1;
      vid_s2   <= vid_s1;
      rgb_out  <= rgb_c;
    end
  end

  // Alarm state and frame counters
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      blink_cnt_q <= '0;
      ring_cnt_q  <= '0;
      phase_q     <= 1'b1;
      ringing     <= 1'b0;
    end else begin
      state_q     <= state_d;
      blink_cnt_q <= blink_cnt_d;
      ring_cnt_q  <= ring_cnt_d;
      phase_q     <= phase_d;
      ringing     <= (state_d == RINGING);
    end
  end

  always_comb begin
    state_d     = state_q;
    blink_cnt_d = blink_cnt_q;
    ring_cnt_d  = ring_cnt_q;
    phase_d     = phase_q;
    timeout_c   = (TIMEOUT_FRAMES != 0) && frame_tick && (ring_cnt_q == RW'(RING_LAST));
    case (state_q)
      IDLE: begin
        if (alarm_req && enable) begin
          state_d     = RINGING;
          blink_cnt_d = '0;
          ring_cnt_d  = '0;
          phase_d     = 1'b1;
        end
      end
      RINGING: begin
        if (!alarm_req || !enable) begin
          state_d = IDLE;
        end else if (ack || timeout_c) begin
          state_d = SILENCED;
        end else if (frame_tick) begin
          if (blink_cnt_q == BW'(BLINK_LAST)) begin
            blink_cnt_d = '0;
            phase_d     = !phase_q;
          end else begin
            blink_cnt_d = blink_cnt_q + BW'(1);
          end
          // Saturating so a disabled or very long timeout never wraps
          if (ring_cnt_q != RW'(TIMEOUT_FRAMES)) ring_cnt_d = ring_cnt_q + RW'(1);
        end
      end
      SILENCED: begin
        if (!alarm_req) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_alarm_icon_overlay.sv
// Scoreboard bench for alarm_icon_overlay: stimulus queues timed expectations,
// a negedge monitor compares them against the DUT outputs.
module tb_alarm_icon_overlay;

  logic        clk = 1'b0;
  logic        reset, alarm_req, enable, ack, frame_tick, video_on;
  logic [9:0]  pix_x, pix_y;
  logic [10:0] rom_addr;
  logic [7:0]  rom_data;
  logic [11:0] rgb_out;
  logic        ringing;

  localparam int K_ADDR = 0;
  localparam int K_RGB  = 1;
  localparam int K_RING = 2;

  typedef struct {
    int          cyc;
    int          kind;
    logic [11:0] val;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  bit   final_chk = 1'b0;
  bit   final_done = 1'b0;

  alarm_icon_overlay #(
    .BLINK_FRAMES   (2),
    .TIMEOUT_FRAMES (5)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .alarm_req  (alarm_req),
    .enable     (enable),
    .ack        (ack),
    .frame_tick (frame_tick),
    .video_on   (video_on),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .rgb_out    (rgb_out),
    .ringing    (ringing)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous font ROM with a few hand-placed rows
  function automatic logic [7:0] rom_fn(input logic [10:0] a);
    case (a)
      11'h060: rom_fn = 8'h80;
      11'h064: rom_fn = 8'h20;
      11'h070: rom_fn = 8'h7F;
      11'h077: rom_fn = 8'h01;
      11'h07F: rom_fn = 8'h01;
      default: rom_fn = 8'h00;
    endcase
  endfunction

  always @(posedge clk) rom_data <= rom_fn(rom_addr);

  function automatic string kname(input int k);
    case (k)
      K_ADDR:  kname = "rom_addr";
      K_RGB:   kname = "rgb_out";
      default: kname = "ringing";
    endcase
  endfunction

  always @(negedge clk) begin
    logic [11:0] act;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        case (sb[i].kind)
          K_ADDR:  act = 12'(rom_addr);
          K_RGB:   act = rgb_out;
          default: act = 12'(ringing);
        endcase
        n_vec++;
        if (act !== sb[i].val) begin
          n_err++;
          $display("FAIL %s cyc=%0d got %h want %h", kname(sb[i].kind), cyc, act, sb[i].val);
        end
        sb.delete(i);
      end
    end
    if (final_chk && !final_done) begin
      foreach (sb[i]) begin
        n_err++;
        $display("FAIL %s never_checked cyc=%0d got none want %h", kname(sb[i].kind), sb[i].cyc, sb[i].val);
      end
      final_done = 1'b1;
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_now(input int kind, input logic [11:0] v);
    sb.push_back('{cyc, kind, v});
  endtask

  task automatic pix(input int x, input int y, input logic v,
                     input logic [10:0] e_addr, input logic [11:0] e_rgb);
    pix_x    = 10'(x);
    pix_y    = 10'(y);
    video_on = v;
    sb.push_back('{cyc + 1, K_ADDR, 12'(e_addr)});
    sb.push_back('{cyc + 3, K_RGB, e_rgb});
    step();
  endtask

  task automatic drain(input int n = 3);
    pix_x    = '0;
    pix_y    = '0;
    video_on = 1'b0;
    step(n);
  endtask

  task automatic pulse(input logic ft, input logic ak);
    frame_tick = ft;
    ack        = ak;
    step();
    frame_tick = 1'b0;
    ack        = 1'b0;
  endtask

  initial begin
    reset = 1'b1; alarm_req = 1'b0; enable = 1'b0; ack = 1'b0; frame_tick = 1'b0;
    video_on = 1'b0; pix_x = '0; pix_y = '0;
    step(2);
    chk_now(K_RING, 12'h0);
    chk_now(K_RGB, 12'h000);
    chk_now(K_ADDR, 12'h000);
    step();
    reset = 1'b0;
    step();

    // Alarm requested but not armed: stays idle, icon blank
    alarm_req = 1'b1;
    pix(576, 320, 1'b1, 11'h060, 12'h000);
    drain();
    chk_now(K_RING, 12'h0);

    enable = 1'b1;
    step();
    chk_now(K_RING, 12'h1);

    // Geometry and glyph decode while ringing, phase on
    pix(576, 320, 1'b1, 11'h060, 12'hF00);
    pix(584, 336, 1'b1, 11'h064, 12'hF00);
    pix(588, 336, 1'b1, 11'h064, 12'h000);
    pix(608, 320, 1'b1, 11'h070, 12'h000);
    pix(636, 348, 1'b1, 11'h077, 12'hF00);
    pix(639, 383, 1'b1, 11'h07F, 12'hF00);
    pix(640, 320, 1'b1, 11'h000, 12'h000);
    pix(575, 320, 1'b1, 11'h000, 12'h000);
    pix(576, 384, 1'b1, 11'h000, 12'h000);
    pix(576, 320, 1'b0, 11'h060, 12'h000);
    drain();

    // Blink: phases after ticks 1..4 are on, off, off, on
    pulse(1'b1, 1'b0); pix(576, 320, 1'b1, 11'h060, 12'hF00); drain();
    pulse(1'b1, 1'b0); pix(576, 320, 1'b1, 11'h060, 12'h000); drain();
    chk_now(K_RING, 12'h1);
    pulse(1'b1, 1'b0); pix(576, 320, 1'b1, 11'h060, 12'h000); drain();
    pulse(1'b1, 1'b0); pix(576, 320, 1'b1, 11'h060, 12'hF00); drain();
    chk_now(K_RING, 12'h1);

    // Fifth tick reaches the timeout and silences
    pulse(1'b1, 1'b0);
    chk_now(K_RING, 12'h0);
    pix(576, 320, 1'b1, 11'h060, 12'h444);
    pix(588, 336, 1'b1, 11'h064, 12'h000);
    drain();
    pulse(1'b0, 1'b1);
    chk_now(K_RING, 12'h0);
    pix(576, 320, 1'b1, 11'h060, 12'h444);
    drain();
    alarm_req = 1'b0;
    step();
    pix(576, 320, 1'b1, 11'h060, 12'h000);
    drain();

    // ack together with enable drop: disarm wins
    alarm_req = 1'b1;
    step();
    chk_now(K_RING, 12'h1);
    ack = 1'b1; enable = 1'b0;
    step();
    ack = 1'b0;
    chk_now(K_RING, 12'h0);
    pix(576, 320, 1'b1, 11'h060, 12'h000);
    drain();
    enable = 1'b1;
    step();
    chk_now(K_RING, 12'h1);

    // Plain ack silences
    pulse(1'b0, 1'b1);
    chk_now(K_RING, 12'h0);
    pix(576, 320, 1'b1, 11'h060, 12'h444);
    drain();
    alarm_req = 1'b0;
    step(2);

    // ack coinciding with the final timeout tick
    alarm_req = 1'b1;
    step();
    chk_now(K_RING, 12'h1);
    repeat (4) pulse(1'b1, 1'b0);
    pix(576, 320, 1'b1, 11'h060, 12'hF00);
    drain();
    pulse(1'b1, 1'b1);
    chk_now(K_RING, 12'h0);
    pix(576, 320, 1'b1, 11'h060, 12'h444);
    drain();
    alarm_req = 1'b0;
    step(2);

    // Reset in the middle of a ringing, lit icon
    alarm_req = 1'b1;
    step();
    pix(576, 320, 1'b1, 11'h060, 12'hF00);
    step(3);
    reset = 1'b1;
    step();
    chk_now(K_RGB, 12'h000);
    chk_now(K_RING, 12'h0);
    chk_now(K_ADDR, 12'h000);
    alarm_req = 1'b0;
    reset = 1'b0;
    pix(576, 320, 1'b1, 11'h060, 12'h000);
    drain(4);

    final_chk = 1'b1;
    @(negedge clk);
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alarm_icon_overlay.md
ALARM_ICON_OVERLAY -- requirements
Module: alarm_icon_overlay

Interface
REQ-001 SHALL have parameter X0, default 576, meaning icon left pixel column.
REQ-002 SHALL have parameter Y0, default 320, meaning icon top pixel row.
REQ-003 SHALL have parameter N_GLYPH, default 2, meaning glyphs placed side by side (1..4).
REQ-004 SHALL have parameter SCALE_LOG2, default 2, meaning each ROM bit drawn as 2^SCALE_LOG2 x 2^SCALE_LOG2 pixels (0..3).
REQ-005 SHALL have parameter GLYPH_BASE, default 7'd6, meaning ROM glyph code of glyph 0; glyph g uses code GLYPH_BASE+g.
REQ-006 SHALL have parameters FG_COLOR 12'hF00, BG_COLOR 12'h000, DIM_COLOR 12'h444, meaning lit, unlit and silenced-lit pixel colours.
REQ-007 SHALL have parameter BLINK_FRAMES, default 15, meaning frame_tick count per blink half-period (>=1).
REQ-008 SHALL have parameter TIMEOUT_FRAMES, default 1800, meaning frames of ringing before auto-silence; 0 disables timeout.
REQ-009 clk  input  1  system/pixel clock.
REQ-010 reset  input  1  synchronous, active-high reset.
REQ-011 alarm_req  input  1  alarm condition from time comparator (level).
REQ-012 enable  input  1  machine ready/armed (level).
REQ-013 ack  input  1  user acknowledge, one-cycle pulse.
REQ-014 frame_tick  input  1  one-cycle pulse once per frame.
REQ-015 video_on, pix_x[9:0], pix_y[9:0]  input  1/10/10  VGA timing of current pixel.
REQ-016 rom_addr  output  11  {glyph code[6:0], row[3:0]} to font ROM.
REQ-017 rom_data  input  8  ROM row, valid one clk after rom_addr; bit 7 = leftmost column.
REQ-018 rgb_out  output  12  overlay colour; ringing  output  1  high in RINGING.

Function
REQ-019 SHALL define S=2^SCALE_LOG2; region: X0<=pix_x<X0+8*N_GLYPH*S and Y0<=pix_y<Y0+16*S.
REQ-020 SHALL compute dx=pix_x-X0, dy=pix_y-Y0; g=dx>>(3+SCALE_LOG2), col=(dx>>SCALE_LOG2)&7, row=(dy>>SCALE_LOG2)&15.
REQ-021 SHALL register rom_addr={GLYPH_BASE+g,row} one clk after pixel (stage 1); outside region rom_addr SHALL hold 0.
REQ-022 SHALL delay col, region flag and video_on two clks to align with rom_data (stage 2); bit = rom_data[7-col].
REQ-023 SHALL register rgb_out at stage 3: total latency 3 clks from pix_x/pix_y/video_on to rgb_out.
REQ-024 rgb_out SHALL be 0 if delayed video_on=0, or outside region, or state IDLE, or RINGING with blink phase off.
REQ-025 Otherwise rgb_out SHALL be FG_COLOR (RINGING, bit=1), DIM_COLOR (SILENCED, bit=1), BG_COLOR (bit=0).
REQ-026 FSM states IDLE, RINGING, SILENCED; ringing=1 only in RINGING.
REQ-027 IDLE->RINGING when alarm_req&&enable; blink phase=on, blink counter=0, ring counter=0 on entry.
REQ-028 RINGING->IDLE when !alarm_req || !enable (highest priority).
REQ-029 RINGING->SILENCED on ack, or on frame_tick when ring counter==TIMEOUT_FRAMES-1 (TIMEOUT_FRAMES>0); simultaneous ack and timeout -> SILENCED.
REQ-030 SILENCED->IDLE when !alarm_req; ack in IDLE/SILENCED SHALL be ignored.
REQ-031 In RINGING each frame_tick SHALL increment blink counter; at BLINK_FRAMES-1 it wraps to 0 and phase toggles.
REQ-032 Ring counter SHALL saturate, not wrap; counters width ceil(log2(max+1)).
REQ-033 State changes mid-frame SHALL take effect on the next stage-3 output; no frame alignment.

Reset
REQ-034 On reset: state IDLE, counters 0, phase on, rom_addr 0, rgb_out 0, ringing 0, pipeline flags 0.
REQ-035 Reset mid-frame or mid-ring SHALL return to IDLE in one clk; rgb_out 0 on first post-reset clk.

Verification
REQ-036 Defaults, alarm_req=enable=1, pix=(576,320), rom_data=8'h80 -> rom_addr=11'h060 at +1, rgb_out=12'hF00 at +3.
REQ-037 Pix (584,336), defaults -> col=2,row=4, rom_addr={6,4}; pix (640,320) -> outside, rgb_out=0.
REQ-038 Ringing, BLINK_FRAMES=2, 4 frame_ticks -> phase on,on,off,off,on; icon pixels 0 while off.
REQ-039 TIMEOUT_FRAMES=3, 3 frame_ticks -> SILENCED, ringing=0, lit pixels=12'h444; alarm_req=0 -> IDLE.
REQ-040 ack and enable=0 same clk -> IDLE; ack with final timeout tick -> SILENCED; reset during RINGING -> IDLE, rgb_out=0.
